seg_to_bcd_capture: RTL and testbench
=====================================

SEG_TO_BCD_CAPTURE -- requirements
Module: seg_to_bcd_capture

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digit slots captured per frame.
REQ-002 Parameter STABLE_CNT, default 3: consecutive identical samples required before a digit is accepted, with a legal range of 1..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sample_en  input  1  one-cycle strobe; seg_n and dig_sel are sampled only when it is high.
REQ-006 seg_n  input  7  active-low segment pattern, bit0=a .. bit6=g.
REQ-007 dig_sel  input  2  index of the digit slot currently driven; values >= NUM_DIGITS are ignored.
REQ-008 bcd_out  output  4*NUM_DIGITS  captured frame, with slot k in bits [4k+3:4k].
REQ-009 digit_err  output  NUM_DIGITS  per-slot flag marking an illegal pattern.
REQ-010 frame_valid  output  1  a captured frame is held on bcd_out/digit_err.
REQ-011 frame_ready  input  1  the consumer accepts the frame when frame_valid && frame_ready.
REQ-012 overrun  output  1  sticky flag indicating a completed frame was dropped.

Function
REQ-013 Decode table, seg_n -> BCD:
  - 1000000 -> 0
  - 1111001 -> 1
  - 0100100 -> 2
  - 0110000 -> 3
  - 0011001 -> 4
  - 0010010 -> 5
  - 0000010 -> 6
  - 1111000 -> 7
  - 0000000 -> 8
  - 0010000 -> 9
  - any other pattern, including blank 1111111 -> value 4'hF with the error bit set.
REQ-014 Stability counter: on each sample_en, if {dig_sel,seg_n} equals the previous sampled pair the counter increments, saturating at 15; otherwise it loads 1 and the pair register updates.
REQ-015 Digit accept: a digit is accepted only on the sample_en where the counter transitions to exactly STABLE_CNT; the decoded value and error bit are written into slot dig_sel of a staging register, and the slot's captured-mask bit is set.
REQ-016 No re-accept: a held-stable digit is not re-accepted until the pair changes.
REQ-017 Slot overwrite: re-accepting an already-captured slot before frame completion overwrites that slot's value.
REQ-018 Frame completion: the frame completes in the cycle the captured mask becomes all-ones; the mask clears in that same cycle.
REQ-019 Frame load: on completion, if frame_valid==0 or frame_ready==1, the staging contents load into bcd_out/digit_err and frame_valid=1 on the next edge; latency from the final sample_en to frame_valid is 1 cycle.
REQ-020 Overrun: on completion while frame_valid==1 and frame_ready==0, the frame is dropped, outputs are unchanged and overrun sets.
REQ-021 Overrun clear: overrun clears on the next accepted handshake.
REQ-022 Handshake without completion: frame_valid && frame_ready with no completion in the same cycle clears frame_valid; bcd_out holds its last value.
REQ-023 Simultaneous handshake and completion: frame_valid stays 1, the new frame loads, and overrun does not set.
REQ-024 Output stability: bcd_out and digit_err do not change while frame_valid==1 && frame_ready==0.
REQ-025 Out-of-range dig_sel: dig_sel >= NUM_DIGITS still updates the pair/counter logic but never writes a slot.

Reset
REQ-026 Output reset values: bcd_out=0, digit_err=0, frame_valid=0, overrun=0.
REQ-027 Internal reset values: captured mask=0, counter=0, pair register=all-ones segments with dig_sel 0.
REQ-028 Reset mid-frame: reset asserted mid-frame discards partial captures; the first sample after reset counts as 1.

Structure
REQ-029 Shared package seg_pkg: holds the ten active-low pattern constants, the BLANK and ERR_CODE (4'hF) constants, and the default NUM_DIGITS.
REQ-030 Sub-module seg7_decode: combinational, seg_n in, bcd and err out; instantiated once, it is the exact inverse of the display encoder table.

Verification
REQ-031 Digit "5", 3 sample_en: present 0010010 on dig_sel 0 for 3 strobes -> slot 0 = 5 after the 3rd strobe, with no accept on the 1st or 2nd strobe.
REQ-032 Full frame "1234": drive slots 0..3 = 1,2,3,4, each stable for 3 strobes, frame_ready=1 -> bcd_out=16'h4321, digit_err=0, frame_valid high 1 cycle after the last strobe.
REQ-033 Illegal digit: slot 2 = 1111111 within a full frame -> bcd_out[11:8]=4'hF, digit_err=4'b0100.
REQ-034 Overrun: complete two frames with frame_ready=0 -> first frame held, overrun=1; then frame_ready=1 for 1 cycle -> frame_valid=0, overrun=0.
REQ-035 Glitch rejection: pattern toggles 0010010/0010000 on every strobe for 10 strobes -> no slot accepted, frame_valid stays 0.
REQ-036 Reset mid-frame: assert rst after 3 of 4 slots are captured, then capture 4 slots -> exactly one frame whose contents are only the post-reset digits.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment pattern constants and capture defaults
//
// Purpose: single source of truth for the active-low segment patterns
//          (bit0=a .. bit6=g) used by the decoder and the capture block.
// Ports:   none (package).
package seg_pkg;

  // Default number of multiplexed digit slots per frame.
  localparam int DEFAULT_NUM_DIGITS = 4;

  // Active-low patterns, written g..a (bit6..bit0).
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Value reported for any pattern that is not a decimal digit.
  localparam logic [3:0] ERR_CODE = 4'hF;

  // Stability counter width and saturation value.
  localparam int         CNT_W   = 4;
  localparam logic [3:0] CNT_MAX = 4'd15;

  // Sampled {dig_sel, seg_n} pair tracked by the stability logic.
  typedef struct packed {
    logic [1:0] sel;
    logic [6:0] seg;
  } sample_pair_t;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational active-low seven-segment to BCD decoder
//
// Purpose: exact inverse of the display encoder table; anything that is not
//          one of the ten digit patterns (blank included) decodes to ERR_CODE
//          with err set.
// Ports:
//   seg_n  in   7  active-low segment pattern, bit0=a .. bit6=g
//   bcd    out  4  decoded digit, or ERR_CODE for an illegal pattern
//   err    out  1  high when the pattern is not a decimal digit
module seg7_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] bcd,
  output logic       err
);

  always_comb begin
    bcd = ERR_CODE;
    err = 1'b0;
    case (seg_n)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: begin
        bcd = ERR_CODE;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_to_bcd_capture.sv
// rtl/seg_to_bcd_capture.sv - debounced capture of a multiplexed 7-seg display into BCD frames
//
// Purpose: samples a multiplexed active-low seven-segment bus, accepts a digit
//          once its {dig_sel, seg_n} pair has been seen STABLE_CNT times in a
//          row, gathers one digit per slot into a staging frame and hands the
//          completed frame to a valid/ready consumer.
// Ports:
//   clk          in   1             rising-edge clock
//   rst          in   1             asynchronous active-high reset
//   sample_en    in   1             strobe; seg_n/dig_sel are sampled when high
//   seg_n        in   7             active-low segment pattern (bit0=a .. bit6=g)
//   dig_sel      in   2             slot currently driven; >= NUM_DIGITS never writes
//   bcd_out      out  4*NUM_DIGITS  captured frame, slot k in [4k+3:4k]
//   digit_err    out  NUM_DIGITS    per-slot illegal-pattern flag
//   frame_valid  out  1             a captured frame is held on the outputs
//   frame_ready  in   1             consumer accepts when frame_valid && frame_ready
//   overrun      out  1             sticky: a completed frame was dropped
module seg_to_bcd_capture
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS,
  parameter int STABLE_CNT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_en,
  input  logic [6:0]              seg_n,
  input  logic [1:0]              dig_sel,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    overrun
);

  localparam logic [CNT_W-1:0] STABLE_Q = CNT_W'(STABLE_CNT);

  sample_pair_t                cur_pair;
  sample_pair_t                pair_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [CNT_W-1:0]            cnt_d;
  logic                        pair_match;
  logic                        accept;

  logic [3:0]                  dec_bcd;
  logic                        dec_err;

  logic [NUM_DIGITS-1:0]       slot_hit;
  logic                        slot_write;
  logic [NUM_DIGITS-1:0]       mask_q;
  logic [NUM_DIGITS-1:0]       mask_d;
  logic [4*NUM_DIGITS-1:0]     stage_bcd_q;
  logic [4*NUM_DIGITS-1:0]     stage_bcd_d;
  logic [NUM_DIGITS-1:0]       stage_err_q;
  logic [NUM_DIGITS-1:0]       stage_err_d;

  logic                        complete;
  logic                        handshake;
  logic                        load_frame;

  seg7_decode u_decode (
    .seg_n (seg_n),
    .bcd   (dec_bcd),
    .err   (dec_err)
  );

  assign cur_pair = '{sel: dig_sel, seg: seg_n};

  // Stability counter. A digit is accepted only on the strobe where the
  // count reaches STABLE_CNT; a saturated counter never re-reaches it, so a
  // held digit is accepted once until the pair changes.
  always_comb begin
    pair_match = (cur_pair == pair_q);
    cnt_d      = cnt_q;
    accept     = 1'b0;
    if (sample_en) begin
      if (pair_match) begin
        if (cnt_q != CNT_MAX) begin
          cnt_d  = cnt_q + 1'b1;
          accept = (cnt_d == STABLE_Q);
        end
      end else begin
        cnt_d  = CNT_W'(1);
        accept = (STABLE_Q == CNT_W'(1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      pair_q <= '{sel: 2'd0, seg: SEG_BLANK};
    end else if (sample_en) begin
      cnt_q <= cnt_d;
      if (!pair_match) begin
        pair_q <= cur_pair;
      end
    end
  end

  // One-hot slot select; an out-of-range dig_sel matches no slot.
  always_comb begin
    slot_hit = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      slot_hit[k] = (dig_sel == 2'(k));
    end
  end

  assign slot_write = accept && (|slot_hit);

  // Next staging contents include the digit being accepted this cycle, so a
  // completing frame can be loaded straight from them.
  always_comb begin
    stage_bcd_d = stage_bcd_q;
    stage_err_d = stage_err_q;
    mask_d      = mask_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (accept && slot_hit[k]) begin
        stage_bcd_d[4*k +: 4] = dec_bcd;
        stage_err_d[k]        = dec_err;
        mask_d[k]             = 1'b1;
      end
    end
  end

  assign complete   = slot_write && (&mask_d);
  assign handshake  = frame_valid && frame_ready;
  assign load_frame = complete && (!frame_valid || frame_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_bcd_q <= '0;
      stage_err_q <= '0;
      mask_q      <= '0;
    end else begin
      stage_bcd_q <= stage_bcd_d;
      stage_err_q <= stage_err_d;
      mask_q      <= complete ? '0 : mask_d;
    end
  end

  // Output frame. A load that coincides with a handshake keeps frame_valid
  // high; a completion that cannot load is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_out     <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (load_frame) begin
        bcd_out     <= stage_bcd_d;
        digit_err   <= stage_err_d;
        frame_valid <= 1'b1;
      end else if (handshake) begin
        frame_valid <= 1'b0;
      end

      if (complete && !load_frame) begin
        overrun <= 1'b1;
      end else if (handshake) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_to_bcd_capture.sv
// tb/tb_seg_to_bcd_capture.sv - self-checking bench for seg_to_bcd_capture
module tb_seg_to_bcd_capture;

  localparam int N  = 4;
  localparam int SC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_en;
  logic [6:0]  seg_n;
  logic [1:0]  dig_sel;
  logic [15:0] bcd_out;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        frame_ready;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_to_bcd_capture #(
    .NUM_DIGITS (N),
    .STABLE_CNT (SC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_en   (sample_en),
    .seg_n       (seg_n),
    .dig_sel     (dig_sel),
    .bcd_out     (bcd_out),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun)
  );

  logic [6:0] pats [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000};

  // Reference model: last sampled pair, run length, staging slots, output frame.
  int m_last_sel, m_last_seg, m_run;
  int m_stage_val [N];
  bit m_stage_err [N];
  bit m_cap [N];
  int m_val [N];
  bit m_err [N];
  bit m_valid, m_ovr;

  function automatic void ref_decode(input logic [6:0] seg, output int val, output bit err);
    val = 15;
    err = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (pats[i] == seg) begin
        val = i;
        err = 1'b0;
      end
    end
  endfunction

  function automatic void model_reset();
    m_last_sel = 0;
    m_last_seg = 7'h7F;
    m_run      = 0;
    for (int i = 0; i < N; i++) begin
      m_stage_val[i] = 0; m_stage_err[i] = 0; m_cap[i] = 0;
      m_val[i] = 0;       m_err[i] = 0;
    end
    m_valid = 0;
    m_ovr   = 0;
  endfunction

  function automatic void model_step(input bit s, input int sel, input logic [6:0] seg, input bit rdy);
    bit hs, acc, done, all;
    int v;
    bit e;
    hs = m_valid && rdy;
    acc = 0;
    done = 0;
    if (s) begin
      if (sel == m_last_sel && int'(seg) == m_last_seg) begin
        acc = (m_run < 15) && (m_run + 1 == SC);
        if (m_run < 15) m_run = m_run + 1;
      end else begin
        m_run = 1;
        acc = (SC == 1);
        m_last_sel = sel;
        m_last_seg = int'(seg);
      end
      if (acc && sel < N) begin
        ref_decode(seg, v, e);
        m_stage_val[sel] = v;
        m_stage_err[sel] = e;
        m_cap[sel] = 1;
        all = 1;
        for (int i = 0; i < N; i++) if (!m_cap[i]) all = 0;
        if (all) begin
          done = 1;
          for (int i = 0; i < N; i++) m_cap[i] = 0;
        end
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        for (int i = 0; i < N; i++) begin
          m_val[i] = m_stage_val[i];
          m_err[i] = m_stage_err[i];
        end
        m_valid = 1;
        if (hs) m_ovr = 0;
      end else begin
        m_ovr = 1;
      end
    end else if (hs) begin
      m_valid = 0;
      m_ovr = 0;
    end
  endfunction

  function automatic logic [15:0] exp_bcd();
    logic [15:0] r = '0;
    for (int i = 0; i < N; i++) r[4*i +: 4] = 4'(m_val[i]);
    return r;
  endfunction

  function automatic logic [3:0] exp_err();
    logic [3:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = m_err[i];
    return r;
  endfunction

  task automatic cycle(input bit s, input int sel, input logic [6:0] seg, input bit rdy);
    logic [31:0] sv;
    @(negedge clk);
    sv = sel;
    sample_en   = s;
    dig_sel     = sv[1:0];
    seg_n       = seg;
    frame_ready = rdy;
    @(posedge clk);
    model_step(s, sel, seg, rdy);
    #1;
  endtask

  task automatic hold_digit(input int sel, input logic [6:0] seg, input int n, input bit rdy);
    repeat (n) cycle(1'b1, sel, seg, rdy);
  endtask

  task automatic test_reset();
    rst = 1'b1; sample_en = 1'b0; seg_n = 7'h7F; dig_sel = 2'd0; frame_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bcd_out !== 16'h0000) begin n_fail++; $display("FAIL reset_bcd: got %h expected 0000", bcd_out); end
    n_checks++; if (digit_err !== 4'b0000) begin n_fail++; $display("FAIL reset_err: got %b expected 0000", digit_err); end
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", frame_valid); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_digit5();
    hold_digit(1, pats[7], 3, 1'b1);
    hold_digit(2, pats[8], 3, 1'b1);
    hold_digit(3, pats[9], 3, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b1, 0, pats[5], 1'b1);
      n_checks++;
      if (frame_valid !== (k == 3)) begin n_fail++; $display("FAIL digit5_strobe%0d_valid: got %b expected %b", k, frame_valid, (k == 3)); end
    end
    n_checks++; if (bcd_out[3:0] !== 4'd5) begin n_fail++; $display("FAIL digit5_slot0: got %h expected 5", bcd_out[3:0]); end
    n_checks++; if (bcd_out !== 16'h9875) begin n_fail++; $display("FAIL digit5_frame: got %h expected 9875", bcd_out); end
    cycle(1'b0, 0, 7'h7F, 1'b1);
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL digit5_handshake: got %b expected 0", frame_valid); end
  endtask

  task automatic test_frame_1234();
    hold_digit(0, pats[1], 3, 1'b1);
    hold_digit(1, pats[2], 3, 1'b1);
    hold_digit(2, pats[3], 3, 1'b1);
    hold_digit(3, pats[4], 2, 1'b1);
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL f1234_early_valid: got %b expected 0", frame_valid); end
    cycle(1'b1, 3, pats[4], 1'b1);
    n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL f1234_valid: got %b expected 1", frame_valid); end
    n_checks++; if (bcd_out !== 16'h4321) begin n_fail++; $display("FAIL f1234_bcd: got %h expected 4321", bcd_out); end
    n_checks++; if (digit_err !== 4'b0000) begin n_fail++; $display("FAIL f1234_err: got %b expected 0000", digit_err); end
    cycle(1'b0, 0, 7'h7F, 1'b1);
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL f1234_clear: got %b expected 0", frame_valid); end
    n_checks++; if (bcd_out !== 16'h4321) begin n_fail++; $display("FAIL f1234_hold: got %h expected 4321", bcd_out); end
  endtask

  task automatic test_illegal();
    hold_digit(0, pats[6], 3, 1'b1);
    hold_digit(1, pats[0], 3, 1'b1);
    hold_digit(2, 7'b1111111, 3, 1'b1);
    hold_digit(3, pats[9], 3, 1'b1);
    n_checks++; if (bcd_out !== 16'h9F06) begin n_fail++; $display("FAIL illegal_bcd: got %h expected 9f06", bcd_out); end
    n_checks++; if (digit_err !== 4'b0100) begin n_fail++; $display("FAIL illegal_err: got %b expected 0100", digit_err); end
    cycle(1'b0, 0, 7'h7F, 1'b1);
  endtask

  task automatic test_overrun();
    hold_digit(0, pats[5], 3, 1'b0);
    hold_digit(1, pats[6], 3, 1'b0);
    hold_digit(2, pats[7], 3, 1'b0);
    hold_digit(3, pats[8], 3, 1'b0);
    n_checks++; if (bcd_out !== 16'h8765 || frame_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_first: got %h/%b expected 8765/1", bcd_out, frame_valid); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first_flag: got %b expected 0", overrun); end
    hold_digit(0, pats[0], 3, 1'b0);
    hold_digit(1, pats[1], 3, 1'b0);
    hold_digit(2, pats[2], 3, 1'b0);
    hold_digit(3, pats[3], 3, 1'b0);
    n_checks++; if (bcd_out !== 16'h8765) begin n_fail++; $display("FAIL ovr_held: got %h expected 8765", bcd_out); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    cycle(1'b0, 0, 7'h7F, 1'b1);
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_hs_valid: got %b expected 0", frame_valid); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 1->0", overrun); end
  endtask

  task automatic test_glitch();
    hold_digit(1, pats[1], 3, 1'b0);
    hold_digit(2, pats[2], 3, 1'b0);
    hold_digit(3, pats[3], 3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 0, (i % 2 == 0) ? pats[5] : pats[9], 1'b0);
      n_checks++;
      if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid%0d: got %b expected 0", i, frame_valid); end
    end
    hold_digit(0, pats[9], 2, 1'b0);
    n_checks++; if (frame_valid !== 1'b1 || bcd_out !== 16'h3219) begin n_fail++; $display("FAIL glitch_settle: got %b/%h expected 1/3219", frame_valid, bcd_out); end
    cycle(1'b0, 0, 7'h7F, 1'b1);
  endtask

  task automatic test_reset_mid();
    hold_digit(0, pats[7], 3, 1'b0);
    hold_digit(1, pats[7], 3, 1'b0);
    hold_digit(2, pats[7], 3, 1'b0);
    hold_digit(3, pats[8], 2, 1'b0);
    @(negedge clk);
    sample_en = 1'b0;
    rst = 1'b1;
    #2;
    model_reset();
    n_checks++; if (frame_valid !== 1'b0 || bcd_out !== 16'h0) begin n_fail++; $display("FAIL rstmid_async: got %b/%h expected 0/0000", frame_valid, bcd_out); end
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 3, pats[8], 1'b0);
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_first_count: got %b expected 0", frame_valid); end
    hold_digit(3, pats[8], 2, 1'b0);
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_mask: got %b expected 0", frame_valid); end
    hold_digit(2, pats[6], 3, 1'b0);
    hold_digit(1, pats[4], 3, 1'b0);
    hold_digit(0, pats[2], 3, 1'b0);
    n_checks++; if (frame_valid !== 1'b1 || bcd_out !== 16'h8642) begin n_fail++; $display("FAIL rstmid_frame: got %b/%h expected 1/8642", frame_valid, bcd_out); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_random();
    int sel, len, done_strobes;
    logic [6:0] seg;
    bit rdy;
    for (int h = 0; h < 400; h++) begin
      sel = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) seg = 7'($urandom);
      else seg = pats[$urandom_range(0, 9)];
      len = ($urandom_range(0, 19) == 0) ? $urandom_range(14, 20) : $urandom_range(1, 5);
      done_strobes = 0;
      while (done_strobes < len) begin
        rdy = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 3) == 0) begin
          cycle(1'b0, sel, seg, rdy);
        end else begin
          cycle(1'b1, sel, seg, rdy);
          done_strobes++;
        end
        n_checks++; if (frame_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid h%0d: got %b expected %b", h, frame_valid, m_valid); end
        n_checks++; if (overrun !== m_ovr) begin n_fail++; $display("FAIL rand_overrun h%0d: got %b expected %b", h, overrun, m_ovr); end
        n_checks++; if (bcd_out !== exp_bcd()) begin n_fail++; $display("FAIL rand_bcd h%0d: got %h expected %h", h, bcd_out, exp_bcd()); end
        n_checks++; if (digit_err !== exp_err()) begin n_fail++; $display("FAIL rand_err h%0d: got %b expected %b", h, digit_err, exp_err()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_digit5();
    test_frame_1234();
    test_illegal();
    test_overrun();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
